// File: rtl/jt7759_pkg.sv
// jt7759_pkg: shared types and constants for the JT7759 sample sequencer.
//   state_t      - sequencer FSM states
//   CMD_*        - opcode field (cmd[7:6]) of a sample-stream command byte
//   MAX_ADDR     - ROM byte holding the last valid phrase index
//   OFS_BASE     - ROM byte of the first phrase offset (big-endian pairs)
//   ofs_addr()   - ROM address of the high/low offset byte of phrase n
package jt7759_pkg;

   typedef enum logic [3:0] {
      IDLE, RD_MAX, RD_HI, RD_LO, RD_CMD, RD_CNT, SIL, PLAY, RPT, DONE
   } state_t;

   localparam logic [1:0] CMD_SIL     = 2'b00;
   localparam logic [1:0] CMD_PLAY256 = 2'b01;
   localparam logic [1:0] CMD_PLAYN   = 2'b10;
   localparam logic [1:0] CMD_RPT     = 2'b11;

   localparam int MAX_ADDR = 0;
   localparam int OFS_BASE = 5;

   // OFS_BASE + 2n + lo, fits in 10 bits for any 8-bit phrase index
   function automatic logic [9:0] ofs_addr(input logic [7:0] n, input logic lo);
      return 10'(OFS_BASE) + {1'b0, n, lo};
   endfunction

endpackage

// File: rtl/jt7759_fetch.sv
// jt7759_fetch: ROM handshake plus one-byte prefetch buffer and nibble selector.
//   req/addr          - FSM wants the byte at addr (level, sampled when idle)
//   rd_ok/rd_data     - read completes this cycle; data straight from the ROM
//   pf_mode           - play mode: completed reads land in the buffer;
//                       when low the buffer is held empty
//   pf_pop            - consume the current nibble (high first, then low)
//   pf_valid/pf_nib   - buffer holds a byte / nibble currently presented
//   rom_cs/rom_addr/rom_data/rom_ok - sample ROM port
module jt7759_fetch #(
   parameter int AW = 17
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req,
   input  logic [AW-1:0] addr,
   output logic          rd_ok,
   output logic [7:0]    rd_data,
   input  logic          pf_mode,
   input  logic          pf_pop,
   output logic          pf_valid,
   output logic [3:0]    pf_nib,
   output logic          rom_cs,
   output logic [AW-1:0] rom_addr,
   input  logic [7:0]    rom_data,
   input  logic          rom_ok
);

   logic [7:0] buf_q;
   logic       nib_hi;   // next nibble to hand out is the high one

   assign rd_ok   = rom_cs & rom_ok;
   assign rd_data = rom_data;
   assign pf_nib  = nib_hi ? buf_q[7:4] : buf_q[3:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_cs   <= 1'b0;
         rom_addr <= '0;
         buf_q    <= 8'd0;
         pf_valid <= 1'b0;
         nib_hi   <= 1'b1;
      end else begin
         // address is latched at request time so it stays stable until rom_ok
         if (rd_ok)
            rom_cs <= 1'b0;
         else if (!rom_cs && req) begin
            rom_cs   <= 1'b1;
            rom_addr <= addr;
         end
         // a load only happens when empty and a pop only when full
         if (!pf_mode) begin
            pf_valid <= 1'b0;
            nib_hi   <= 1'b1;
         end else if (rd_ok) begin
            buf_q    <= rom_data;
            pf_valid <= 1'b1;
            nib_hi   <= 1'b1;
         end else if (pf_pop) begin
            if (nib_hi) nib_hi   <= 1'b0;
            else        pf_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/jt7759_seq.sv
// jt7759_seq: phrase lookup and command-stream sequencer for the JT7759 core.
//   clk/rst            - system clock, async active-high reset
//   cen_ctl/cen_dec    - control-rate and decoder-rate enables from the divider
//   start/phrase       - playback request (rising edge) and phrase index
//   busyn              - low while a phrase is sequenced
//   rom_*              - sample ROM read port
//   divby              - divider setting for the current block
//   dec_rst/dec_en/dec_din - decoder clear, nibble strobe and nibble
//   silent             - high when idle or in a silence block
module jt7759_seq
   import jt7759_pkg::*;
#(
   parameter int AW      = 17,
   parameter int SIL_LEN = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen_ctl,
   input  logic          cen_dec,
   input  logic          start,
   input  logic [7:0]    phrase,
   output logic          busyn,
   output logic          rom_cs,
   output logic [AW-1:0] rom_addr,
   input  logic [7:0]    rom_data,
   input  logic          rom_ok,
   output logic [5:0]    divby,
   output logic          dec_rst,
   output logic          dec_en,
   output logic [3:0]    dec_din,
   output logic          silent
);

   localparam int CW = 9;   // holds 256 nibbles and SIL_LEN ticks

   state_t        st;
   logic          start_l;
   logic [7:0]    phr, ofs_hi;
   logic [AW-1:0] ptr, loop_addr, rd_addr;
   logic [2:0]    rpt_cnt, rpt_n;
   logic [CW-1:0] cnt;
   logic          skip;     // swallow the first cen_dec of a block after dec_rst
   logic          req, rd_ok, pf_valid, pop;
   logic [7:0]    rd_data;
   logic [3:0]    pf_nib;

   always_comb begin
      rd_addr = ptr;
      case (st)
         RD_MAX:  rd_addr = AW'(MAX_ADDR);
         RD_HI:   rd_addr = AW'(ofs_addr(phr, 1'b0));
         RD_LO:   rd_addr = AW'(ofs_addr(phr, 1'b1));
         default: ;
      endcase
   end

   // no prefetch once the count is exhausted, so an odd count never pulls
   // in a byte past the block
   assign req = (st inside {RD_MAX, RD_HI, RD_LO, RD_CMD, RD_CNT}) ||
                (st == PLAY && !pf_valid && cnt != '0);
   assign pop = st == PLAY && cen_dec && !skip && pf_valid && cnt != '0;

   jt7759_fetch #(.AW(AW)) u_fetch (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .addr     (rd_addr),
      .rd_ok    (rd_ok),
      .rd_data  (rd_data),
      .pf_mode  (st == PLAY),
      .pf_pop   (pop),
      .pf_valid (pf_valid),
      .pf_nib   (pf_nib),
      .rom_cs   (rom_cs),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .rom_ok   (rom_ok)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= IDLE;
         start_l   <= 1'b0;
         busyn     <= 1'b1;
         divby     <= 6'd0;
         dec_rst   <= 1'b0;
         dec_en    <= 1'b0;
         dec_din   <= 4'd0;
         silent    <= 1'b1;
         phr       <= 8'd0;
         ofs_hi    <= 8'd0;
         ptr       <= '0;
         loop_addr <= '0;
         rpt_cnt   <= 3'd0;
         rpt_n     <= 3'd0;
         cnt       <= '0;
         skip      <= 1'b0;
      end else begin
         start_l <= start;
         dec_rst <= 1'b0;
         dec_en  <= 1'b0;
         // nibble service comes first; FSM below still sees the old count
         if (pop) begin
            dec_en  <= 1'b1;
            dec_din <= pf_nib;
            cnt     <= cnt - CW'(1);
         end
         if (st == PLAY && cen_dec) skip <= 1'b0;
         if (st == SIL && cen_dec && cnt != '0) cnt <= cnt - CW'(1);
         case (st)
            IDLE: if (start && !start_l) begin
               phr     <= phrase;
               busyn   <= 1'b0;
               rpt_cnt <= 3'd0;
               st      <= RD_MAX;
            end
            RD_MAX: if (rd_ok) st <= (phr > rd_data) ? DONE : RD_HI;
            RD_HI: if (rd_ok) begin
               ofs_hi <= rd_data;
               st     <= RD_LO;
            end
            RD_LO: if (rd_ok) begin
               ptr <= AW'({ofs_hi, rd_data, 1'b0});
               st  <= RD_CMD;
            end
            RD_CMD: if (rd_ok) begin
               ptr <= ptr + AW'(1);
               case (rd_data[7:6])
                  CMD_SIL: begin
                     if (rd_data[5:0] == 6'd0) begin
                        // end of phrase doubles as the loop-back point
                        if (rpt_cnt != 3'd0) begin
                           rpt_cnt <= rpt_cnt - 3'd1;
                           ptr     <= loop_addr;
                        end else
                           st <= DONE;
                     end else begin
                        divby  <= rd_data[5:0];
                        silent <= 1'b1;
                        cnt    <= CW'(SIL_LEN);
                        st     <= SIL;
                     end
                  end
                  CMD_PLAY256: begin
                     divby   <= rd_data[5:0];
                     cnt     <= CW'(256);
                     dec_rst <= 1'b1;
                     skip    <= 1'b1;
                     silent  <= 1'b0;
                     st      <= PLAY;
                  end
                  CMD_PLAYN: begin
                     divby <= rd_data[5:0];
                     st    <= RD_CNT;
                  end
                  default: begin
                     rpt_n <= rd_data[2:0];
                     st    <= RPT;
                  end
               endcase
            end
            RD_CNT: if (rd_ok) begin
               ptr     <= ptr + AW'(1);
               cnt     <= {1'b0, rd_data} + CW'(1);
               dec_rst <= 1'b1;
               skip    <= 1'b1;
               silent  <= 1'b0;
               st      <= PLAY;
            end
            RPT: if (cen_ctl) begin
               // only one loop level: a repeat inside a running loop is ignored
               if (rpt_cnt == 3'd0) begin
                  loop_addr <= ptr;
                  rpt_cnt   <= rpt_n;
               end
               st <= RD_CMD;
            end
            SIL: if (cen_ctl && cnt == '0) st <= RD_CMD;
            PLAY: begin
               if (rd_ok) ptr <= ptr + AW'(1);
               if (cen_ctl && cnt == '0) st <= RD_CMD;
            end
            DONE: if (cen_ctl) begin
               busyn  <= 1'b1;
               silent <= 1'b1;
               st     <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/jt7759_seq.md
# jt7759_seq

Sample sequencer for the JT7759 ADPCM core. On a start request it looks up a phrase in the sample ROM table and parses the per-sample command stream: silence, fixed-length play, variable-length play, and block repeat. It programs the clock divider's `divby` for each block and feeds nibbles to the ADPCM decoder on every decoder clock-enable. It sits between the host interface, the sample ROM port, the clock divider (whose `cen_ctl`/`cen_dec` it consumes) and the ADPCM decoder.

## Interface
Parameters:
- `AW`, 17: ROM address width (128 kB sample space).
- `SIL_LEN`, 32: number of `cen_dec` ticks per silence block.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous active-high reset.
- `cen_ctl` in 1: control-rate enable from the divider; all FSM steps advance only on it.
- `cen_dec` in 1: decoder-rate enable from the divider; one nibble per tick.
- `start` in 1: level; a rising edge (sampled every `clk`) requests playback.
- `phrase` in 8: phrase index, latched on the `start` rising edge.
- `busyn` out 1: low while a phrase is being sequenced.
- `rom_cs` out 1: ROM read request.
- `rom_addr` out AW: ROM byte address.
- `rom_data` in 8: ROM read data.
- `rom_ok` in 1: `rom_data` valid for the current `rom_addr` while `rom_cs` is high.
- `divby` out 6: divider setting for the divider block.
- `dec_rst` out 1: one-cycle decoder state clear at the start of each play block.
- `dec_en` out 1: nibble strobe; one `clk` wide, aligned to `cen_dec`.
- `dec_din` out 4: nibble to the decoder.
- `silent` out 1: high in idle and during silence blocks.

## Operation
- Reset values: `busyn`=1, `rom_cs`=0, `rom_addr`=0, `divby`=0, `dec_rst`=0, `dec_en`=0, `dec_din`=0, `silent`=1, FSM=IDLE, repeat count=0.
- ROM table layout:
  - byte 0 = last valid phrase index (max).
  - phrase n offset is big-endian at bytes 5+2n and 6+2n.
  - sample address = offset<<1, truncated to AW bits.
- Every ROM read: assert `rom_cs` with a stable address and wait for `rom_ok`. Hold all state until then. The data is captured on the `rom_ok` cycle and `rom_cs` drops the next cycle.
- FSM states: IDLE → RD_MAX → RD_HI → RD_LO → RD_CMD → {SIL, RD_CNT, PLAY, RPT} → RD_CMD … → DONE → IDLE.
- IDLE: on the `start` rising edge, latch `phrase`, drive `busyn`=0, go to RD_MAX.
- RD_MAX: if `phrase` > max, go to DONE. Otherwise read both offset bytes.
- RD_CMD: read the byte at the sample pointer, then advance the pointer by 1. Decode on bits [7:6]:
  - 00 with low bits = 0: end of phrase; go to DONE.
  - 00 with low bits ≠ 0: silence. `divby`=cmd[5:0], `silent`=1, wait `SIL_LEN` `cen_dec` ticks.
  - 01: play 256 nibbles, `divby`=cmd[5:0].
  - 10: read the next byte c, play c+1 nibbles, `divby`=cmd[5:0].
  - 11: repeat. Store the current pointer as the loop address and set the repeat count to cmd[2:0]. The following blocks run until the next RD_CMD that reaches an end-of-phrase (00h) byte. At that point, if count>0, decrement it and jump back to the loop address; otherwise go to DONE. A repeat command seen while count>0 is ignored (no nesting).
- PLAY:
  - `dec_rst` pulses once on entry.
  - Nibbles go out high nibble first.
  - Bytes are fetched into a one-byte prefetch buffer so the next byte is requested as soon as the current one is consumed.
  - On each `cen_dec`, if a nibble is available: `dec_en`=1 and `dec_din`=nibble, and the remaining count decrements.
  - If the buffer is empty (ROM slow): `dec_en` stays 0 for that tick and the count does not decrement (underrun stretch).
  - When the count reaches 0, go to RD_CMD. An odd count leaves the trailing low nibble unused; the pointer still skips that whole byte.
- DONE: `silent`=1, `busyn`=1, return to IDLE.
- A `start` edge while `busyn`=0 is ignored.
- `rst` mid-phrase returns everything to reset values immediately.
- `divby` changes only on RD_CMD decode. The divider applies it at its own end of count.

## Timing
- `start` edge to `busyn` low: 1 `clk`.
- FSM transitions occur on `cen_ctl` cycles, except ROM-wait exits, which occur on the `rom_ok` cycle.
- `dec_en`/`dec_din` are registered: they are valid the `clk` after `cen_dec` is seen high, and `dec_en` is high for exactly 1 `clk`.
- `dec_rst` is high for 1 `clk`, at least one `cen_dec` before the first `dec_en` of the block.
- Simultaneous `cen_ctl` and `cen_dec`: the nibble output is serviced first and FSM decoding proceeds in the same cycle.
- Pointer wrap: the sample pointer wraps modulo 2^AW.

## Structure
- Shared package `jt7759_pkg` holds:
  - FSM state enum.
  - Command opcode constants (CMD_SIL, CMD_PLAY256, CMD_PLAYN, CMD_RPT).
  - Table constants (MAX_ADDR=0, OFS_BASE=5).
- Sub-module `jt7759_fetch`: ROM handshake plus the one-byte prefetch buffer and nibble selector. It has a request/valid interface to the FSM.

## Test plan
- ROM byte0=2, phrase 1 offset 0x0010, data at 0x20 = 0x45, 128 bytes, then 0x00. Start with phrase=1 → `divby`=5, `dec_rst` pulse, 256 `dec_en` strobes in ROM nibble order (high first), `busyn` high after the 00h byte.
- phrase=3 with max=2 → `busyn` low→high with no reads past bytes 0/5/6; no `dec_en`.
- Command 0x8A, count byte 0x04, 3 data bytes → `divby`=10, exactly 5 nibbles, the last byte's low nibble dropped, next command read from the following address.
- Command 0x03 → `silent`=1, `divby`=3, 32 `cen_dec` ticks with no `dec_en`, then next command.
- Command 0xC2 followed by a play block and 00h → play block emitted 3 times, then DONE.
- `rom_ok` held low 50 cycles mid-play → `dec_en` gaps, no lost or duplicated nibbles. Assert `rst` mid-play → all outputs at reset values the same cycle.
